mem_req_arbiter: RTL and testbench

Schedules the I/D cache and uncached requesters onto the single shared memory-bus bridge. There are four read sources (DUncache word, DCache line, IUncache word, ICache line) and two write sources (DUncache word, DCache line write-back).
- Selects one read and one write transaction at a time and drives the bridge's request/address/length controls.
- Routes the bridge's completion pulse back to the granted requester.
- Enforces MMIO ordering and DCache read-after-write-back line hazards.
- Data buses bypass this block; the bridge steers data using the one-hot grant outputs.

---
 rtl/mem_req_arbiter_pkg.sv | 12 +
 rtl/mem_req_arbiter_if.sv | 33 +++
 rtl/mem_req_arbiter_prio_pick4.sv | 17 +
 rtl/mem_req_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_req_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// mem_arb_pkg: requester indices, FSM state types and line geometry shared by mem_req_arbiter
package mem_arb_pkg;
    localparam int LINE_OFF_W = 5;
    localparam int RD_DUC = 0;
    localparam int RD_DC  = 1;
    localparam int RD_IUC = 2;
    localparam int RD_IC  = 3;
    localparam int WR_DUC = 0;
    localparam int WR_DC  = 1;
    typedef enum logic {R_IDLE, R_BUSY} rd_state_t;
    typedef enum logic {W_IDLE, W_BUSY} wr_state_t;
endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_arb_if: requester and bridge signal bundle for mem_req_arbiter
interface mem_arb_if #(
    parameter int ADDR_W = 32
);
    logic [3:0]          rd_req_i;
    logic [4*ADDR_W-1:0] rd_addr_i;
    logic [3:0]          rd_done_o;
    logic [1:0]          wr_req_i;
    logic [2*ADDR_W-1:0] wr_addr_i;
    logic [3:0]          wr_strb_i;
    logic [1:0]          wr_done_o;
    logic                bus_rd_req_o;
    logic [ADDR_W-1:0]   bus_rd_addr_o;
    logic                bus_rd_line_o;
    logic [3:0]          bus_rd_gnt_o;
    logic                bus_rd_done_i;
    logic                bus_wr_req_o;
    logic [ADDR_W-1:0]   bus_wr_addr_o;
    logic                bus_wr_line_o;
    logic [3:0]          bus_wr_strb_o;
    logic [1:0]          bus_wr_gnt_o;
    logic                bus_wr_done_i;
    modport slave (
        input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_strb_i, bus_rd_done_i, bus_wr_done_i,
        output rd_done_o, wr_done_o, bus_rd_req_o, bus_rd_addr_o, bus_rd_line_o, bus_rd_gnt_o,
               bus_wr_req_o, bus_wr_addr_o, bus_wr_line_o, bus_wr_strb_o, bus_wr_gnt_o
    );
    modport master (
        output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_strb_i, bus_rd_done_i, bus_wr_done_i,
        input  rd_done_o, wr_done_o, bus_rd_req_o, bus_rd_addr_o, bus_rd_line_o, bus_rd_gnt_o,
               bus_wr_req_o, bus_wr_addr_o, bus_wr_line_o, bus_wr_strb_o, bus_wr_gnt_o
    );
endinterface

// File: rtl/mem_req_arbiter_prio_pick4.sv
// prio_pick4: one-hot fixed-priority picker (lowest index wins), optionally preferring the I-side pair
module prio_pick4
    import mem_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic       i_first,
    output logic [3:0] gnt
);
    logic [3:0] d_gnt, i_gnt;
    assign d_gnt = req & (~req + 4'd1);
    always_comb begin
        i_gnt = '0;
        i_gnt[RD_IUC] = req[RD_IUC];
        i_gnt[RD_IC] = req[RD_IC] && !req[RD_IUC];
    end
    assign gnt = (i_first && |req[RD_IC:RD_IUC]) ? i_gnt : d_gnt;
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: schedules I/D cache and uncached requesters onto the shared bus bridge.
// Define MEM_ARB_STARVE_GUARD_EN to let a waiting I-side read win after STARVE_LIMIT D-side grants.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef MEM_ARB_STARVE_GUARD_EN
    , parameter int STARVE_LIMIT = 4
`endif
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);
    localparam int TAG_W = ADDR_W - LINE_OFF_W;
    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;
    logic [3:0] rd_elig, rd_pick, rd_gnt;
    logic [1:0] wr_pick, wr_gnt;
    logic [ADDR_W-1:0] rd_sel_addr, rd_addr, wr_sel_addr, wr_addr;
    logic [3:0] wr_sel_strb, wr_strb;
    logic rd_sel_line, rd_line, wr_line, i_first, dc_hazard;
    logic [TAG_W-1:0] dc_tag, wb_tag, fl_tag;
    assign dc_tag = bus.rd_addr_i[RD_DC*ADDR_W+LINE_OFF_W +: TAG_W];
    assign wb_tag = bus.wr_addr_i[WR_DC*ADDR_W+LINE_OFF_W +: TAG_W];
    assign fl_tag = wr_addr[ADDR_W-1:LINE_OFF_W];
    // A write-back still queued or on the bus owns its line until it completes.
    assign dc_hazard = (bus.wr_req_i[WR_DC] && wb_tag == dc_tag) || (wr_gnt[WR_DC] && fl_tag == dc_tag);
    always_comb begin
        rd_elig = 4'b1111;
        rd_elig[RD_DUC] = !(bus.wr_req_i[WR_DUC] || wr_gnt[WR_DUC]);
        rd_elig[RD_DC] = !dc_hazard;
    end
    prio_pick4 u_pick (
        .req    (bus.rd_req_i & rd_elig & {4{rd_state == R_IDLE}}),
        .i_first(i_first),
        .gnt    (rd_pick)
    );
    always_comb begin
        rd_sel_addr = '0;
        for (int i = 0; i < 4; i++)
            if (rd_pick[i]) rd_sel_addr = bus.rd_addr_i[i*ADDR_W +: ADDR_W];
        rd_sel_line = rd_pick[RD_DC] || rd_pick[RD_IC];
        if (rd_sel_line) rd_sel_addr[LINE_OFF_W-1:0] = '0;
    end
    assign wr_pick = (wr_state != W_IDLE) ? 2'b00 :
                     bus.wr_req_i[WR_DUC] ? 2'b01 : {bus.wr_req_i[WR_DC], 1'b0};
    assign wr_sel_addr = wr_pick[WR_DUC] ? bus.wr_addr_i[WR_DUC*ADDR_W +: ADDR_W] : {wb_tag, {LINE_OFF_W{1'b0}}};
    assign wr_sel_strb = wr_pick[WR_DUC] ? bus.wr_strb_i : 4'b1111;
    always_comb begin
        rd_next = rd_state;
        wr_next = wr_state;
        rd_next = (rd_state == R_IDLE) ? (|rd_pick ? R_BUSY : R_IDLE) : (bus.bus_rd_done_i ? R_IDLE : R_BUSY);
        wr_next = (wr_state == W_IDLE) ? (|wr_pick ? W_BUSY : W_IDLE) : (bus.bus_wr_done_i ? W_IDLE : W_BUSY);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_gnt   <= '0;
            rd_addr  <= '0;
            rd_line  <= 1'b0;
        end else begin
            rd_state <= rd_next;
            if (|rd_pick) begin
                rd_gnt  <= rd_pick;
                rd_addr <= rd_sel_addr;
                rd_line <= rd_sel_line;
            end else if (rd_state == R_BUSY && bus.bus_rd_done_i) begin
                rd_gnt  <= '0;
                rd_addr <= '0;
                rd_line <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_gnt   <= '0;
            wr_addr  <= '0;
            wr_line  <= 1'b0;
            wr_strb  <= '0;
        end else begin
            wr_state <= wr_next;
            if (|wr_pick) begin
                wr_gnt  <= wr_pick;
                wr_addr <= wr_sel_addr;
                wr_line <= wr_pick[WR_DC];
                wr_strb <= wr_sel_strb;
            end else if (wr_state == W_BUSY && bus.bus_wr_done_i) begin
                wr_gnt  <= '0;
                wr_addr <= '0;
                wr_line <= 1'b0;
                wr_strb <= '0;
            end
        end
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    logic [STREAK_W-1:0] streak;
    // Counts D-side wins only while an I-side read is actually waiting.
    always_ff @(posedge clk) begin
        if (rst || bus.rd_req_i[RD_IC:RD_IUC] == 2'b00) streak <= '0;
        else if (|rd_pick) streak <= |rd_pick[RD_IC:RD_IUC] ? '0 : streak + STREAK_W'(1);
    end
    assign i_first = streak == STREAK_W'(STARVE_LIMIT);
`else
    assign i_first = 1'b0;
`endif
    assign bus.bus_rd_req_o  = rd_state == R_BUSY;
    assign bus.bus_rd_addr_o = rd_addr;
    assign bus.bus_rd_line_o = rd_line;
    assign bus.bus_rd_gnt_o  = rd_gnt;
    assign bus.rd_done_o     = rd_gnt & {4{bus.bus_rd_done_i}};
    assign bus.bus_wr_req_o  = wr_state == W_BUSY;
    assign bus.bus_wr_addr_o = wr_addr;
    assign bus.bus_wr_line_o = wr_line;
    assign bus.bus_wr_strb_o = wr_strb;
    assign bus.bus_wr_gnt_o  = wr_gnt;
    assign bus.wr_done_o     = wr_gnt & {2{bus.bus_wr_done_i}};
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_req_arbiter;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    mem_arb_if #(.ADDR_W(32)) bus ();
    mem_req_arbiter #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic clr_in();
        bus.rd_req_i = '0;
        bus.rd_addr_i = '0;
        bus.wr_req_i = '0;
        bus.wr_addr_i = '0;
        bus.wr_strb_i = '0;
        bus.bus_rd_done_i = 1'b0;
        bus.bus_wr_done_i = 1'b0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int i, input logic [31:0] a);
        bus.rd_req_i[i] = 1'b1;
        bus.rd_addr_i[i*32 +: 32] = a;
    endtask

    task automatic set_wr(input int i, input logic [31:0] a, input logic [3:0] s);
        bus.wr_req_i[i] = 1'b1;
        bus.wr_addr_i[i*32 +: 32] = a;
        bus.wr_strb_i = s;
    endtask

    task automatic rd_finish(input int i);
        bus.bus_rd_done_i = 1'b1;
        tick();
        bus.bus_rd_done_i = 1'b0;
        bus.rd_req_i[i] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h1C00_0000 + 32'($urandom_range(3)) * 32'h20 + 32'($urandom_range(7)) * 32'h4;
    endfunction

    task automatic test_reset();
        clr_in();
        rst = 1'b1;
        tick(2);
        checks++;
        if ({bus.bus_rd_req_o, bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o} !== 38'h0) begin
            errors++;
            $display("FAIL reset_rd: got %h expected 0", {bus.bus_rd_req_o, bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o});
        end
        checks++;
        if ({bus.bus_wr_req_o, bus.bus_wr_gnt_o, bus.bus_wr_line_o, bus.bus_wr_strb_o, bus.bus_wr_addr_o} !== 40'h0) begin
            errors++;
            $display("FAIL reset_wr: got %h expected 0", {bus.bus_wr_req_o, bus.bus_wr_gnt_o, bus.bus_wr_line_o, bus.bus_wr_strb_o, bus.bus_wr_addr_o});
        end
        rst = 1'b0;
        tick();
        bus.bus_rd_done_i = 1'b1;
        bus.bus_wr_done_i = 1'b1;
        #1;
        checks++;
        if ({bus.rd_done_o, bus.wr_done_o} !== 6'h0) begin
            errors++;
            $display("FAIL idle_done: got %b expected 000000", {bus.rd_done_o, bus.wr_done_o});
        end
        tick();
        clr_in();
    endtask

    task automatic test_line_read();
        set_rd(1, 32'h1000_0024);
        set_rd(3, 32'h2000_0008);
        #1;
        checks++;
        if (bus.bus_rd_gnt_o !== 4'b0000) begin
            errors++;
            $display("FAIL latency: gnt got %b expected 0000", bus.bus_rd_gnt_o);
        end
        tick();
        checks++;
        if ({bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o} !== {4'b0010, 1'b1, 32'h1000_0020}) begin
            errors++;
            $display("FAIL dc_grant: got %b %b %h expected 0010 1 10000020", bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o);
        end
        tick(2);
        checks++;
        if ({bus.bus_rd_req_o, bus.bus_rd_gnt_o, bus.bus_rd_addr_o} !== {1'b1, 4'b0010, 32'h1000_0020}) begin
            errors++;
            $display("FAIL dc_hold: got %b %b %h expected 1 0010 10000020", bus.bus_rd_req_o, bus.bus_rd_gnt_o, bus.bus_rd_addr_o);
        end
        bus.bus_rd_done_i = 1'b1;
        #1;
        checks++;
        if (bus.rd_done_o !== 4'b0010) begin
            errors++;
            $display("FAIL dc_done: got %b expected 0010", bus.rd_done_o);
        end
        tick();
        bus.bus_rd_done_i = 1'b0;
        bus.rd_req_i[1] = 1'b0;
        #1;
        checks++;
        if ({bus.rd_done_o, bus.bus_rd_gnt_o} !== 8'h00) begin
            errors++;
            $display("FAIL gap_cycle: done/gnt got %b %b expected 0000 0000", bus.rd_done_o, bus.bus_rd_gnt_o);
        end
        tick();
        checks++;
        if ({bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o} !== {4'b1000, 1'b1, 32'h2000_0000}) begin
            errors++;
            $display("FAIL ic_grant: got %b %b %h expected 1000 1 20000000", bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o);
        end
        rd_finish(3);
    endtask

    task automatic test_hazard();
        set_wr(1, 32'h1C00_0040, 4'b0000);
        set_rd(1, 32'h1C00_0044);
        tick();
        checks++;
        if ({bus.bus_wr_gnt_o, bus.bus_wr_line_o, bus.bus_wr_strb_o, bus.bus_wr_addr_o, bus.bus_rd_gnt_o} !==
            {2'b10, 1'b1, 4'b1111, 32'h1C00_0040, 4'b0000}) begin
            errors++;
            $display("FAIL wb_grant: wgnt %b wline %b strb %b waddr %h rgnt %b expected 10 1 1111 1c000040 0000",
                     bus.bus_wr_gnt_o, bus.bus_wr_line_o, bus.bus_wr_strb_o, bus.bus_wr_addr_o, bus.bus_rd_gnt_o);
        end
        tick();
        checks++;
        if (bus.bus_rd_gnt_o !== 4'b0000) begin
            errors++;
            $display("FAIL hazard_block: rgnt got %b expected 0000", bus.bus_rd_gnt_o);
        end
        bus.bus_wr_done_i = 1'b1;
        #1;
        checks++;
        if ({bus.wr_done_o, bus.bus_rd_gnt_o} !== {2'b10, 4'b0000}) begin
            errors++;
            $display("FAIL wb_done: wdone %b rgnt %b expected 10 0000", bus.wr_done_o, bus.bus_rd_gnt_o);
        end
        tick();
        bus.bus_wr_done_i = 1'b0;
        bus.wr_req_i[1] = 1'b0;
        #1;
        checks++;
        if ({bus.bus_wr_req_o, bus.bus_rd_gnt_o} !== 5'b0) begin
            errors++;
            $display("FAIL after_wb: wreq %b rgnt %b expected 0 0000", bus.bus_wr_req_o, bus.bus_rd_gnt_o);
        end
        tick();
        checks++;
        if ({bus.bus_rd_gnt_o, bus.bus_rd_addr_o} !== {4'b0010, 32'h1C00_0040}) begin
            errors++;
            $display("FAIL hazard_release: got %b %h expected 0010 1c000040", bus.bus_rd_gnt_o, bus.bus_rd_addr_o);
        end
        rd_finish(1);
        set_wr(1, 32'h1C00_0040, 4'b0000);
        tick();
        set_rd(1, 32'h1C00_0060);
        tick();
        checks++;
        if ({bus.bus_rd_gnt_o, bus.bus_rd_addr_o, bus.bus_wr_gnt_o} !== {4'b0010, 32'h1C00_0060, 2'b10}) begin
            errors++;
            $display("FAIL other_line: rgnt %b raddr %h wgnt %b expected 0010 1c000060 10", bus.bus_rd_gnt_o, bus.bus_rd_addr_o, bus.bus_wr_gnt_o);
        end
        bus.bus_rd_done_i = 1'b1;
        bus.bus_wr_done_i = 1'b1;
        tick();
        clr_in();
        tick();
    endtask

    task automatic test_mmio();
        set_wr(0, 32'h4000_0010, 4'b0011);
        set_rd(0, 32'h4000_0014);
        tick();
        checks++;
        if ({bus.bus_wr_gnt_o, bus.bus_wr_line_o, bus.bus_wr_strb_o, bus.bus_wr_addr_o, bus.bus_rd_gnt_o} !==
            {2'b01, 1'b0, 4'b0011, 32'h4000_0010, 4'b0000}) begin
            errors++;
            $display("FAIL mmio_wr: wgnt %b wline %b strb %b waddr %h rgnt %b expected 01 0 0011 40000010 0000",
                     bus.bus_wr_gnt_o, bus.bus_wr_line_o, bus.bus_wr_strb_o, bus.bus_wr_addr_o, bus.bus_rd_gnt_o);
        end
        tick();
        bus.bus_wr_done_i = 1'b1;
        #1;
        checks++;
        if ({bus.wr_done_o, bus.bus_rd_gnt_o} !== {2'b01, 4'b0000}) begin
            errors++;
            $display("FAIL mmio_done: wdone %b rgnt %b expected 01 0000", bus.wr_done_o, bus.bus_rd_gnt_o);
        end
        tick();
        bus.bus_wr_done_i = 1'b0;
        bus.wr_req_i[0] = 1'b0;
        #1;
        checks++;
        if (bus.bus_rd_gnt_o !== 4'b0000) begin
            errors++;
            $display("FAIL mmio_order: rgnt got %b expected 0000", bus.bus_rd_gnt_o);
        end
        tick();
        checks++;
        if ({bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o} !== {4'b0001, 1'b0, 32'h4000_0014}) begin
            errors++;
            $display("FAIL mmio_rd: got %b %b %h expected 0001 0 40000014", bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o);
        end
        rd_finish(0);
    endtask

    task automatic test_starve();
        logic [3:0] exp_gnt;
        set_rd(1, 32'h1C00_0000);
        set_rd(3, 32'h0800_0000);
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_gnt = (GUARD && k == 4) ? 4'b1000 : 4'b0010;
            checks++;
            if (bus.bus_rd_gnt_o !== exp_gnt) begin
                errors++;
                $display("FAIL starve_arb%0d: gnt got %b expected %b", k, bus.bus_rd_gnt_o, exp_gnt);
            end
            bus.bus_rd_done_i = 1'b1;
            tick();
            bus.bus_rd_done_i = 1'b0;
        end
        bus.rd_req_i = '0;
        tick();
    endtask

    task automatic test_dual_done();
        set_rd(2, 32'h0000_1004);
        set_wr(1, 32'h2000_0004, 4'b0000);
        tick();
        checks++;
        if ({bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o, bus.bus_wr_gnt_o, bus.bus_wr_addr_o} !==
            {4'b0100, 1'b0, 32'h0000_1004, 2'b10, 32'h2000_0000}) begin
            errors++;
            $display("FAIL dual_grant: rgnt %b rline %b raddr %h wgnt %b waddr %h expected 0100 0 00001004 10 20000000",
                     bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o, bus.bus_wr_gnt_o, bus.bus_wr_addr_o);
        end
        bus.bus_rd_done_i = 1'b1;
        bus.bus_wr_done_i = 1'b1;
        #1;
        checks++;
        if ({bus.rd_done_o, bus.wr_done_o} !== {4'b0100, 2'b10}) begin
            errors++;
            $display("FAIL dual_done: got %b %b expected 0100 10", bus.rd_done_o, bus.wr_done_o);
        end
        tick();
        clr_in();
        #1;
        checks++;
        if ({bus.bus_rd_req_o, bus.bus_wr_req_o} !== 2'b00) begin
            errors++;
            $display("FAIL dual_idle: got %b expected 00", {bus.bus_rd_req_o, bus.bus_wr_req_o});
        end
        tick();
    endtask

    task automatic test_rst_mid();
        set_rd(3, 32'h3000_0044);
        set_wr(0, 32'h5000_0000, 4'b1100);
        tick();
        checks++;
        if ({bus.bus_rd_req_o, bus.bus_wr_req_o} !== 2'b11) begin
            errors++;
            $display("FAIL rst_pre: busy got %b expected 11", {bus.bus_rd_req_o, bus.bus_wr_req_o});
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.bus_rd_req_o, bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o,
             bus.bus_wr_req_o, bus.bus_wr_gnt_o, bus.bus_wr_line_o, bus.bus_wr_strb_o, bus.bus_wr_addr_o} !== 78'h0) begin
            errors++;
            $display("FAIL rst_mid: got rd %b %b %h wr %b %b %b %h expected all 0", bus.bus_rd_req_o, bus.bus_rd_gnt_o,
                     bus.bus_rd_addr_o, bus.bus_wr_req_o, bus.bus_wr_gnt_o, bus.bus_wr_strb_o, bus.bus_wr_addr_o);
        end
        clr_in();
        rst = 1'b0;
        bus.bus_rd_done_i = 1'b1;
        bus.bus_wr_done_i = 1'b1;
        #1;
        checks++;
        if ({bus.rd_done_o, bus.wr_done_o} !== 6'h0) begin
            errors++;
            $display("FAIL rst_stray_done: got %b expected 000000", {bus.rd_done_o, bus.wr_done_o});
        end
        tick();
        clr_in();
        tick();
    endtask

    task automatic test_random();
        int ro, wo, streak, nro, nwo, idx;
        bit ok, ifirst;
        logic [31:0] ra, wa, a;
        logic [3:0] ws, e_rgnt, e_rdone;
        logic [1:0] e_wgnt, e_wdone;
        ro = -1; wo = -1; streak = 0; ra = '0; wa = '0; ws = '0;
        clr_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            e_rgnt = (ro < 0) ? 4'b0 : 4'(1 << ro);
            e_wgnt = (wo < 0) ? 2'b0 : 2'(1 << wo);
            e_rdone = bus.bus_rd_done_i ? e_rgnt : 4'b0;
            e_wdone = bus.bus_wr_done_i ? e_wgnt : 2'b0;
            checks++;
            if ({bus.bus_rd_req_o, bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o, bus.rd_done_o} !==
                {ro >= 0, e_rgnt, ro == 1 || ro == 3, (ro < 0) ? 32'h0 : ra, e_rdone}) begin
                errors++;
                $display("FAIL rand_rd cyc=%0d: got req %b gnt %b line %b addr %h done %b expected owner %0d addr %h done %b",
                         cyc, bus.bus_rd_req_o, bus.bus_rd_gnt_o, bus.bus_rd_line_o, bus.bus_rd_addr_o, bus.rd_done_o,
                         ro, ra, e_rdone);
            end
            checks++;
            if ({bus.bus_wr_req_o, bus.bus_wr_gnt_o, bus.bus_wr_line_o, bus.bus_wr_strb_o, bus.bus_wr_addr_o, bus.wr_done_o} !==
                {wo >= 0, e_wgnt, wo == 1, (wo < 0) ? 4'h0 : ws, (wo < 0) ? 32'h0 : wa, e_wdone}) begin
                errors++;
                $display("FAIL rand_wr cyc=%0d: got req %b gnt %b line %b strb %b addr %h done %b expected owner %0d strb %b addr %h done %b",
                         cyc, bus.bus_wr_req_o, bus.bus_wr_gnt_o, bus.bus_wr_line_o, bus.bus_wr_strb_o, bus.bus_wr_addr_o,
                         bus.wr_done_o, wo, ws, wa, e_wdone);
            end
            @(posedge clk);
            if (rst) begin
                ro = -1; wo = -1; streak = 0;
            end else begin
                nro = ro;
                nwo = wo;
                if (ro >= 0) begin
                    if (bus.bus_rd_done_i) nro = -1;
                end else begin
                    ifirst = GUARD && streak == 4;
                    for (int k = 0; k < 4; k++) begin
                        idx = ifirst ? (k + 2) % 4 : k;
                        a = bus.rd_addr_i[idx*32 +: 32];
                        ok = 1'b1;
                        if (idx == 0) ok = !(bus.wr_req_i[0] || wo == 0);
                        if (idx == 1) ok = !((bus.wr_req_i[1] && bus.wr_addr_i[63:37] == a[31:5]) || (wo == 1 && wa[31:5] == a[31:5]));
                        if (nro < 0 && bus.rd_req_i[idx] && ok) begin
                            nro = idx;
                            ra = (idx % 2 == 1) ? {a[31:5], 5'b0} : a;
                        end
                    end
                    if (nro >= 0 && bus.rd_req_i[3:2] != 2'b00) streak = (nro >= 2) ? 0 : streak + 1;
                end
                if (bus.rd_req_i[3:2] == 2'b00) streak = 0;
                if (wo >= 0) begin
                    if (bus.bus_wr_done_i) nwo = -1;
                end else if (bus.wr_req_i[0]) begin
                    nwo = 0; wa = bus.wr_addr_i[31:0]; ws = bus.wr_strb_i;
                end else if (bus.wr_req_i[1]) begin
                    nwo = 1; wa = {bus.wr_addr_i[63:37], 5'b0}; ws = 4'hF;
                end
                ro = nro;
                wo = nwo;
            end
            #1;
            rst = (cyc % 700 == 699);
            for (int i = 0; i < 4; i++) begin
                if (e_rdone[i] || (ro == i && $urandom_range(15) == 0)) bus.rd_req_i[i] = 1'b0;
                else if (!bus.rd_req_i[i] && $urandom_range(3) == 0) begin
                    bus.rd_req_i[i] = 1'b1;
                    bus.rd_addr_i[i*32 +: 32] = rand_addr();
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (e_wdone[i]) bus.wr_req_i[i] = 1'b0;
                else if (!bus.wr_req_i[i] && $urandom_range(3) == 0) begin
                    bus.wr_req_i[i] = 1'b1;
                    bus.wr_addr_i[i*32 +: 32] = rand_addr();
                    if (i == 0) bus.wr_strb_i = 4'($urandom_range(15));
                end
            end
            bus.bus_rd_done_i = ($urandom_range(2) == 0);
            bus.bus_wr_done_i = ($urandom_range(2) == 0);
        end
        clr_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_read();
        test_hazard();
        test_mmio();
        test_starve();
        test_dual_done();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
